// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer control path.
// Holds the controller state encoding, the speed_mode codes and a small helper
// that maps the fast-forward / rewind switches onto a speed code.
package song_pkg;

  // Controller state encoding (3 bits).
  localparam logic [2:0] S_PAUSED  = 3'd0;
  localparam logic [2:0] S_PLAYING = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_STOPPED = 3'd4;

  typedef enum logic [2:0] {
    StPaused  = S_PAUSED,
    StPlaying = S_PLAYING,
    StSkip    = S_SKIP,
    StAdvance = S_ADVANCE,
    StStopped = S_STOPPED
  } state_e;

  // speed_mode codes; 2'd3 is never produced.
  localparam logic [1:0] SPD_NORMAL = 2'd0;
  localparam logic [1:0] SPD_FF     = 2'd1;
  localparam logic [1:0] SPD_REW    = 2'd2;

  // Speed is only non-NORMAL while playing; conflicting switches cancel out.
  function automatic logic [1:0] speed_decode(input logic play, input logic ff,
                                              input logic rew);
    logic [1:0] spd;
    spd = SPD_NORMAL;
    if (play) begin
      if (ff && !rew) begin
        spd = SPD_FF;
      end else if (rew && !ff) begin
        spd = SPD_REW;
      end
    end
    return spd;
  endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Front-panel / player bus of the song sequencer.
// Inputs to the sequencer: play_button, next_button (one-cycle pulses),
// ff_switch0, r_switch1 (levels), song_done (level from the song reader).
// Outputs from the sequencer: play, current_song, reset_player, speed_mode.
// master: the side driving the buttons/switches and observing the player controls.
// slave:  the sequencer itself.
interface song_sequencer_if #(
  parameter int unsigned SONG_W = 2
) ();

  logic              play_button;
  logic              next_button;
  logic              ff_switch0;
  logic              r_switch1;
  logic              song_done;
  logic              play;
  logic [SONG_W-1:0] current_song;
  logic              reset_player;
  logic [1:0]        speed_mode;

  modport master (
    output play_button,
    output next_button,
    output ff_switch0,
    output r_switch1,
    output song_done,
    input  play,
    input  current_song,
    input  reset_player,
    input  speed_mode
  );

  modport slave (
    input  play_button,
    input  next_button,
    input  ff_switch0,
    input  r_switch1,
    input  song_done,
    output play,
    output current_song,
    output reset_player,
    output speed_mode
  );

endinterface

// File: rtl/song_index_counter.sv
// Song index register with increment, optional wrap and an is_last flag.
// Ports:
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset (index returns to 0)
//   inc_i     - advance the index this cycle
//   wrap_i    - when incrementing from the last song: 1 = go to 0, 0 = hold
//   idx_o     - current song index, always in 0..NUM_SONGS-1
//   is_last_o - idx_o is the last song
module song_index_counter #(
  parameter int unsigned SONG_W    = 2,
  parameter int unsigned NUM_SONGS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              wrap_i,
  output logic [SONG_W-1:0] idx_o,
  output logic              is_last_o
);

  localparam logic [SONG_W-1:0] LastIdx = SONG_W'(NUM_SONGS - 1);

  logic [SONG_W-1:0] idx_d, idx_q;

  assign is_last_o = (idx_q == LastIdx);
  assign idx_o     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (inc_i) begin
      if (is_last_o) begin
        if (wrap_i) begin
          idx_d = '0;
        end
      end else begin
        idx_d = idx_q + SONG_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Music player control unit: turns front-panel pulses and speed switches into
// play enable, song index, a one-cycle player reset and a speed mode.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave side of song_sequencer_if (buttons, switches, song_done in;
//           play, current_song, reset_player, speed_mode out; all outputs registered)
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned NUM_SONGS    = 4,
  parameter int unsigned SONG_W       = 2,
  parameter bit          AUTO_ADVANCE = 1'b1,
  parameter bit          WRAP         = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  song_sequencer_if.slave    bus
);

  state_e state_d, state_q;

  logic              play_d, play_q;
  logic              reset_player_d, reset_player_q;
  logic [1:0]        speed_d, speed_q;
  logic              inc;
  logic              wrap;
  logic              is_last;
  logic [SONG_W-1:0] song_idx;

  song_index_counter #(
    .SONG_W   (SONG_W),
    .NUM_SONGS(NUM_SONGS)
  ) u_index (
    .clk_i    (clk),
    .rst_ni   (reset),
    .inc_i    (inc),
    .wrap_i   (wrap),
    .idx_o    (song_idx),
    .is_last_o(is_last)
  );

  // Next state and index control. The index moves on the edge that leaves
  // SKIP/ADVANCE, so a reset during those cycles leaves no partial increment.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    wrap    = 1'b1;
    unique case (state_q)
      StPaused: begin
        if (bus.next_button) begin
          state_d = StSkip;
        end else if (bus.play_button) begin
          state_d = StPlaying;
        end
      end
      StPlaying: begin
        if (bus.next_button) begin
          state_d = StSkip;
        end else if (bus.play_button) begin
          state_d = StPaused;
        end else if (bus.song_done) begin
          state_d = AUTO_ADVANCE ? StAdvance : StPaused;
        end
      end
      StSkip: begin
        // Manual skip always wraps regardless of WRAP.
        inc     = 1'b1;
        wrap    = 1'b1;
        state_d = StPaused;
      end
      StAdvance: begin
        inc  = 1'b1;
        wrap = WRAP;
        if (is_last && !WRAP) begin
          state_d = StStopped;
        end else begin
          state_d = StPlaying;
        end
      end
      StStopped: begin
        if (bus.next_button || bus.play_button) begin
          state_d = StSkip;
        end
      end
      default: begin
        state_d = StPaused;
      end
    endcase
  end

  // Outputs are derived from the state being entered, so they line up with it.
  always_comb begin
    play_d         = (state_d == StPlaying);
    reset_player_d = (state_d == StSkip) || (state_d == StAdvance);
    speed_d        = speed_decode(play_d, bus.ff_switch0, bus.r_switch1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StPaused;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
      speed_q        <= SPD_NORMAL;
    end else begin
      state_q        <= state_d;
      play_q         <= play_d;
      reset_player_q <= reset_player_d;
      speed_q        <= speed_d;
    end
  end

  assign bus.play         = play_q;
  assign bus.current_song = song_idx;
  assign bus.reset_player = reset_player_q;
  assign bus.speed_mode   = speed_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two instances share the button/switch stimulus,
// A with WRAP=1 and B with WRAP=0 (both auto-advance). A behavioural model of
// the player is compared against both on every falling edge out of reset,
// plus literal checks at key points of the directed sequence.
module tb_song_sequencer;

  localparam int NSONG  = 4;
  localparam bit WRAP_A = 1'b1;
  localparam bit WRAP_B = 1'b0;

  // Model modes.
  localparam int MPAUSE = 0;
  localparam int MPLAY  = 1;
  localparam int MSTOP  = 2;
  localparam int MSKIP  = 3;
  localparam int MADV   = 4;

  logic clk;
  logic rst_n;
  logic pb, nb, ff, rw;
  logic sd [2];

  int total;
  int bad;

  int m_mode [2];
  int m_song [2];
  int e_play [2];
  int e_rp   [2];
  int e_spd  [2];

  song_sequencer_if #(.SONG_W(2)) if_a ();
  song_sequencer_if #(.SONG_W(2)) if_b ();

  assign if_a.play_button = pb;
  assign if_a.next_button = nb;
  assign if_a.ff_switch0  = ff;
  assign if_a.r_switch1   = rw;
  assign if_a.song_done   = sd[0];
  assign if_b.play_button = pb;
  assign if_b.next_button = nb;
  assign if_b.ff_switch0  = ff;
  assign if_b.r_switch1   = rw;
  assign if_b.song_done   = sd[1];

  song_sequencer #(
    .NUM_SONGS   (NSONG),
    .SONG_W      (2),
    .AUTO_ADVANCE(1'b1),
    .WRAP        (WRAP_A)
  ) dut_a (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if_a)
  );

  song_sequencer #(
    .NUM_SONGS   (NSONG),
    .SONG_W      (2),
    .AUTO_ADVANCE(1'b1),
    .WRAP        (WRAP_B)
  ) dut_b (
    .clk  (clk),
    .reset(rst_n),
    .bus  (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the player as seen from the front panel.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = MPAUSE;
        m_song[k] = 0;
      end else begin
        if (m_mode[k] == MSKIP) begin
          m_song[k] = (m_song[k] + 1) % NSONG;
          m_mode[k] = MPAUSE;
        end else if (m_mode[k] == MADV) begin
          if (m_song[k] == NSONG - 1 && !((k == 0) ? WRAP_A : WRAP_B)) begin
            m_mode[k] = MSTOP;
          end else begin
            m_song[k] = (m_song[k] + 1) % NSONG;
            m_mode[k] = MPLAY;
          end
        end else if (nb) begin
          m_mode[k] = MSKIP;
        end else if (pb) begin
          if (m_mode[k] == MPAUSE) m_mode[k] = MPLAY;
          else if (m_mode[k] == MPLAY) m_mode[k] = MPAUSE;
          else m_mode[k] = MSKIP;
        end else if (sd[k] && m_mode[k] == MPLAY) begin
          m_mode[k] = MADV;
        end
      end
      e_play[k] = (m_mode[k] == MPLAY) ? 1 : 0;
      e_rp[k]   = (m_mode[k] == MSKIP || m_mode[k] == MADV) ? 1 : 0;
      if (e_play[k] == 0 || ff == rw) e_spd[k] = 0;
      else e_spd[k] = ff ? 1 : 2;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_play", int'(if_a.play), e_play[0]);
      check("a_song", int'(if_a.current_song), m_song[0]);
      check("a_rp", int'(if_a.reset_player), e_rp[0]);
      check("a_spd", int'(if_a.speed_mode), e_spd[0]);
      check("b_play", int'(if_b.play), e_play[1]);
      check("b_song", int'(if_b.current_song), m_song[1]);
      check("b_rp", int'(if_b.reset_player), e_rp[1]);
      check("b_spd", int'(if_b.speed_mode), e_spd[1]);
    end
  end

  // Advance n falling edges; the song reader drops song_done once reset_player is seen.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (e_rp[k] != 0) sd[k] = 1'b0;
      end
    end
  endtask

  task automatic press(input logic p, input logic n);
    tick(1);
    pb = p;
    nb = n;
    tick(1);
    pb = 1'b0;
    nb = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    pb = 1'b0; nb = 1'b0; ff = 1'b0; rw = 1'b0;
    sd[0] = 1'b0; sd[1] = 1'b0;
    #22;
    check("rst_play", int'(if_a.play), 0);
    check("rst_rp", int'(if_a.reset_player), 0);
    rst_n = 1'b1;
    tick(25);
    check("idle_song", int'(if_a.current_song), 0);
    check("idle_play", int'(if_b.play), 0);

    // Play from pause.
    press(1'b1, 1'b0);
    check("t1_play", int'(if_a.play), 1);
    check("t1_song", int'(if_a.current_song), 0);

    // Skip while playing.
    press(1'b0, 1'b1);
    check("t2_rp", int'(if_a.reset_player), 1);
    check("t2_play", int'(if_a.play), 0);
    tick(1);
    check("t2_rp_low", int'(if_a.reset_player), 0);
    check("t2_song", int'(if_a.current_song), 1);
    press(1'b1, 1'b0);
    check("t2_replay", int'(if_a.play), 1);

    // Get to song 3 playing, then end the song.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    tick(1);
    check("t3_song3", int'(if_b.current_song), 3);
    press(1'b1, 1'b0);
    sd[0] = 1'b1;
    sd[1] = 1'b1;
    tick(1);
    check("t3_rp", int'(if_a.reset_player), 1);
    check("t3_play0", int'(if_a.play), 0);
    tick(1);
    check("t3_a_song", int'(if_a.current_song), 0);
    check("t3_a_play", int'(if_a.play), 1);
    check("t4_b_song", int'(if_b.current_song), 3);
    check("t4_b_play", int'(if_b.play), 0);
    check("t4_b_rp", int'(if_b.reset_player), 0);

    // Play from STOPPED restarts at song 0, paused.
    press(1'b1, 1'b0);
    check("t4_b_skip", int'(if_b.reset_player), 1);
    tick(1);
    check("t4_b_song0", int'(if_b.current_song), 0);
    check("t4_b_paused", int'(if_b.play), 0);

    // Speed switches.
    press(1'b1, 1'b0);
    ff = 1'b1;
    tick(1);
    check("t5_ff", int'(if_a.speed_mode), 1);
    rw = 1'b1;
    tick(1);
    check("t5_both", int'(if_a.speed_mode), 0);
    ff = 1'b0;
    tick(1);
    check("t5_rew", int'(if_b.speed_mode), 2);
    press(1'b1, 1'b0);
    check("t5_pause", int'(if_a.speed_mode), 0);
    rw = 1'b0;

    // Simultaneous next and play: skip wins; reset during the skip cycle.
    press(1'b0, 1'b1);
    tick(1);
    press(1'b1, 1'b1);
    check("t6_play", int'(if_a.play), 0);
    check("t6_rp", int'(if_a.reset_player), 1);
    check("t6_song", int'(if_a.current_song), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_song", int'(if_a.current_song), 0);
    check("t6_rst_rp", int'(if_a.reset_player), 0);
    check("t6_rst_b_rp", int'(if_b.reset_player), 0);
    tick(2);
    #2;
    rst_n = 1'b1;
    tick(3);
    check("t6_after_song", int'(if_a.current_song), 0);
    press(1'b1, 1'b0);
    check("t6_after_play", int'(if_a.play), 1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Control unit for the music player. It turns debounced front-panel pulses (play, next) and the speed switches into the play enable, the song index, a one-cycle player-reset pulse and a speed mode. It sits between the button/switch conditioning logic and the song reader / note player datapath. It replaces ad-hoc control with an explicit state machine that also supports auto-advance at end of song.

Parameters:
NUM_SONGS, 4, number of songs in ROM; must be 2..2**SONG_W.
SONG_W, 2, width of the song index.
AUTO_ADVANCE, 1, 1 = song_done moves to the next song and keeps playing; 0 = song_done pauses.
WRAP, 1, 1 = the last song advances to song 0; 0 = the last song ends in STOPPED.

Ports:
clk  input  1  system clock; every register is on the rising edge.
reset  input  1  asynchronous, active-low (0 = reset); only one clock domain.
play_button  input  1  debounced one-cycle pulse; toggles play/pause.
next_button  input  1  debounced one-cycle pulse; skip to the next song.
ff_switch0  input  1  level; fast-forward request.
r_switch1  input  1  level; rewind request.
song_done  input  1  level from the song reader; the current song has finished. Held until reset_player.
play  output  1  registered play enable to the note player / song reader.
current_song  output  SONG_W  registered song index.
reset_player  output  1  registered one-cycle pulse; clears the song reader and note player.
speed_mode  output  2  registered; 0 = NORMAL, 1 = FF, 2 = REWIND; 3 is never driven.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = PAUSED, play=0, current_song=0, reset_player=0, speed_mode=NORMAL.
  - Release is taken synchronously; the first decision happens on the first rising edge with reset=1.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N, so the latency is 1 cycle.
- State PAUSED (play=0):
  - next_button -> SKIP.
  - Otherwise play_button -> PLAYING.
  - song_done is ignored.
- State PLAYING (play=1):
  - next_button -> SKIP.
  - Otherwise play_button -> PAUSED.
  - Otherwise song_done=1:
    - AUTO_ADVANCE=1 -> ADVANCE.
    - AUTO_ADVANCE=0 -> PAUSED. Player state is kept, and song_done stays pending until the next skip.
- State SKIP (1 cycle):
  - reset_player=1, play=0.
  - current_song <= (current_song==NUM_SONGS-1) ? 0 : current_song+1. WRAP does not apply to manual skip.
  - Next state is always PAUSED.
- State ADVANCE (1 cycle):
  - reset_player=1, play=0.
  - If current_song==NUM_SONGS-1 and WRAP=0 -> STOPPED, with current_song held.
  - Otherwise increment with wrap and go to PLAYING, so play=1 is restored on the following cycle.
- State STOPPED (play=0):
  - play_button -> SKIP, which restarts from song 0 paused.
  - next_button -> SKIP.
- Priority inside one cycle: next_button > play_button > song_done. Buttons arriving during SKIP or ADVANCE are dropped; there is no queuing.
- reset_player is high for exactly one cycle per SKIP or ADVANCE and low in every other state.
- speed_mode:
  - Updated every cycle. If play=0 it is NORMAL.
  - Otherwise: ff_switch0 & ~r_switch1 -> FF; r_switch1 & ~ff_switch0 -> REWIND; both or neither -> NORMAL.
  - It uses the play value being registered in the same cycle, so speed_mode is never non-NORMAL while play=0.
- current_song never exceeds NUM_SONGS-1.
- Reset asserted mid-SKIP or mid-ADVANCE: all outputs go to reset values immediately, and no partial increment survives.

Decomposition:
- Shared package song_pkg holds:
  - the state encoding localparams (S_PAUSED, S_PLAYING, S_SKIP, S_ADVANCE, S_STOPPED; 3 bits);
  - the speed_mode codes (SPD_NORMAL=0, SPD_FF=1, SPD_REW=2).
- One sub-module is natural: song_index_counter (SONG_W-bit, inc/wrap/hold, with an is_last flag). It is reused by the playlist display logic.
- The FSM and the speed_mode decode stay in song_sequencer.

Test Plan:
1. Release reset, wait 25 cycles, then play_button pulse -> play=1 one cycle later; current_song=0; reset_player never pulsed.
2. While playing song 0, next_button pulse -> reset_player=1 for exactly 1 cycle; current_song=1; play=0. Then play_button -> play=1.
3. AUTO_ADVANCE=1, WRAP=1, playing song 3, raise song_done -> ADVANCE: reset_player pulse, current_song=0, play=1 again two cycles after song_done.
4. WRAP=0, song 3, song_done -> current_song stays 3, play=0, state STOPPED. Then play_button -> current_song=0, paused.
5. Playing with ff_switch0=1 -> speed_mode=1. Then r_switch1=1 as well -> 0. Then ff_switch0=0 -> 2. Then pause -> 0.
6. next_button and play_button in the same cycle -> SKIP wins (play=0, song+1). Pull reset low during the SKIP cycle -> current_song=0 and reset_player=0 asynchronously.
